// File: rtl/line_mem_responder.sv
// line_mem_responder: line-granularity memory end of the cache swap-in /
// swap-out interface. Level-held rd_req/wr_req are accepted in IDLE, the
// access completes LATENCY cycles later, and gnt pulses for one cycle.
// Optional build macro: MEM_ACCESS_CNT_EN adds the rd_cnt/wr_cnt completion
// counters and their ports.
//
// state  | meaning
// IDLE   | waiting for a request
// BUSY   | request latched, counting access latency
// DONE   | access complete, gnt high for this cycle
module line_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  parameter int LATENCY       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [31:0]         wr_line [2**LINE_ADDR_LEN],
  output logic [31:0]         rd_line [2**LINE_ADDR_LEN],
  output logic                gnt
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [31:0]         rd_cnt,
  output logic [31:0]         wr_cnt
`endif
);

  localparam int LINE_SIZE = 2**LINE_ADDR_LEN;
  localparam int DEPTH     = 2**ADDR_LEN;
  localparam int CW        = $clog2(LATENCY) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic                r_op_wr;
  logic [ADDR_LEN-1:0] r_addr;
  logic [31:0]         r_wdata [LINE_SIZE];
  logic [31:0]         r_mem   [DEPTH][LINE_SIZE];
  // A line reads back its own word address until it is first written.
  // This flag vector has no reset so reset never disturbs storage; it
  // relies on flops powering up cleared.
  logic [DEPTH-1:0]    r_written;
  logic [31:0]         w_rd_word [LINE_SIZE];
  logic                w_any_req;
  logic                w_accept;
  logic                w_commit;

  assign w_any_req = rd_req | wr_req;
  assign gnt       = (r_state == S_DONE);

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode: accept in IDLE, abort or complete in BUSY
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!w_any_req) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_commit    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage read view of the latched line, with power-up address pattern
  always_comb begin
    for (int i = 0; i < LINE_SIZE; i++) begin
      w_rd_word[i] = r_written[r_addr] ? r_mem[r_addr][i]
                                       : 32'({r_addr, LINE_ADDR_LEN'(i)});
    end
  end

  // Request latch, latency counter and registered read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_op_wr <= 1'b0;
      r_addr  <= '0;
      for (int i = 0; i < LINE_SIZE; i++) begin
        r_wdata[i] <= '0;
        rd_line[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_op_wr <= wr_req;
        r_addr  <= addr;
        for (int i = 0; i < LINE_SIZE; i++) r_wdata[i] <= wr_line[i];
      end else if (r_state == S_BUSY && !w_commit) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_commit && !r_op_wr) begin
        for (int i = 0; i < LINE_SIZE; i++) rd_line[i] <= w_rd_word[i];
      end
    end
  end

  // Storage write on completion of a write; reset leaves contents alone
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && r_op_wr) begin
      for (int i = 0; i < LINE_SIZE; i++) r_mem[r_addr][i] <= r_wdata[i];
      r_written[r_addr] <= 1'b1;
    end
  end

`ifdef MEM_ACCESS_CNT_EN
  // Completed-access counters, free-running with natural wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (w_commit) begin
      if (r_op_wr) wr_cnt <= wr_cnt + 32'd1;
      else         rd_cnt <= rd_cnt + 32'd1;
    end
  end
`endif

endmodule
